// File: rtl/elevator_ctrl_n_if.sv
// Call-button inputs and status/lamp outputs of the elevator controller core.
// Buttons are plain level/pulse inputs with no valid/ready: a bit high at a clock edge is a request at that edge, and the core never back-pressures.
interface elevator_ctrl_n_if #(
    parameter int N_FLOORS = 5,
    parameter int FLOOR_W  = 3
);
    logic [N_FLOORS-1:0] hall_up_req;
    logic [N_FLOORS-1:0] hall_dn_req;
    logic [N_FLOORS-1:0] car_req;
    logic [FLOOR_W-1:0]  cur_floor;
    logic                moving_up;
    logic                moving_dn;
    logic                door_open;
    logic                busy;
    logic [N_FLOORS-1:0] pend_up;
    logic [N_FLOORS-1:0] pend_dn;
    logic [N_FLOORS-1:0] pend_car;
    logic [1:0]          dbg_state;
    logic                dbg_dir;

    modport master (
        output hall_up_req, hall_dn_req, car_req,
        input  cur_floor, moving_up, moving_dn, door_open, busy,
        input  pend_up, pend_dn, pend_car, dbg_state, dbg_dir
    );

    modport slave (
        input  hall_up_req, hall_dn_req, car_req,
        output cur_floor, moving_up, moving_dn, door_open, busy,
        output pend_up, pend_dn, pend_car, dbg_state, dbg_dir
    );
endinterface

// File: rtl/elevator_ctrl_n.sv
// Parametrised elevator controller: latches hall/car calls and serves them with
// directional-collective (SCAN) scheduling, a per-floor travel timer and a door timer.
module elevator_ctrl_n #(
    parameter int N_FLOORS      = 5,
    parameter int FLOOR_W       = 3,
    parameter int CNT_W         = 32,
    parameter int TRAVEL_CYCLES = 100000000,
    parameter int DOOR_CYCLES   = 100000000
) (
    input logic              clk,
    input logic              rst,
    elevator_ctrl_n_if.slave bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MOVE_UP = 2'd1;
    localparam logic [1:0] S_MOVE_DN = 2'd2;
    localparam logic [1:0] S_DOOR    = 2'd3;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);

    // No up call from the top floor, no down call from the bottom floor.
    localparam logic [N_FLOORS-1:0] UP_MASK = {1'b0, {(N_FLOORS-1){1'b1}}};
    localparam logic [N_FLOORS-1:0] DN_MASK = {{(N_FLOORS-1){1'b1}}, 1'b0};

    logic [1:0]          state, state_nx;
    logic                dir, dir_nx;
    logic [FLOOR_W-1:0]  floor_q, floor_nx;
    logic [CNT_W-1:0]    travel_cnt, travel_cnt_nx;
    logic [CNT_W-1:0]    door_cnt, door_cnt_nx;
    logic [N_FLOORS-1:0] pend_up_q, pend_dn_q, pend_car_q;
    logic [N_FLOORS-1:0] clr_up, clr_dn, clr_car;
    logic [N_FLOORS-1:0] req_up, req_dn, pend_any;
    logic [FLOOR_W-1:0]  floor_up, floor_dn, svc_floor;
    logic                here, above, below;
    logic                enter_door, svc_dir, ahead, door_req;

    function automatic logic any_above(input logic [N_FLOORS-1:0] p,
                                       input logic [FLOOR_W-1:0] f);
        any_above = 1'b0;
        for (int i = 0; i < N_FLOORS; i++)
            if (i > int'(f)) any_above = any_above | p[i];
    endfunction

    function automatic logic any_below(input logic [N_FLOORS-1:0] p,
                                       input logic [FLOOR_W-1:0] f);
        any_below = 1'b0;
        for (int i = 0; i < N_FLOORS; i++)
            if (i < int'(f)) any_below = any_below | p[i];
    endfunction

    assign req_up   = bus.hall_up_req & UP_MASK;
    assign req_dn   = bus.hall_dn_req & DN_MASK;
    assign pend_any = pend_up_q | pend_dn_q | pend_car_q;
    assign here     = pend_any[floor_q];
    assign above    = any_above(pend_any, floor_q);
    assign below    = any_below(pend_any, floor_q);
    assign floor_up = floor_q + FLOOR_W'(1);
    assign floor_dn = floor_q - FLOOR_W'(1);
    assign door_req = bus.car_req[floor_q] |
                      ((dir == DIR_UP) ? req_up[floor_q] : req_dn[floor_q]);

    always_comb begin
        state_nx      = state;
        dir_nx        = dir;
        floor_nx      = floor_q;
        travel_cnt_nx = travel_cnt;
        door_cnt_nx   = door_cnt;
        clr_up        = '0;
        clr_dn        = '0;
        clr_car       = '0;
        enter_door    = 1'b0;
        svc_floor     = floor_q;
        svc_dir       = dir;
        ahead         = 1'b0;

        case (state)
            S_IDLE: begin
                if (here) begin
                    enter_door = 1'b1;
                    // Serving only the opposite hall call here means turning round first,
                    // otherwise that call would never clear and the door would recycle.
                    if (!(pend_car_q[floor_q] ||
                          ((dir == DIR_UP) ? pend_up_q[floor_q] : pend_dn_q[floor_q])))
                        svc_dir = ~dir;
                end else if (above && below) begin
                    state_nx = (dir == DIR_UP) ? S_MOVE_UP : S_MOVE_DN;
                end else if (above) begin
                    dir_nx   = DIR_UP;
                    state_nx = S_MOVE_UP;
                end else if (below) begin
                    dir_nx   = DIR_DN;
                    state_nx = S_MOVE_DN;
                end
            end
            S_MOVE_UP: begin
                if (travel_cnt == TRAVEL_LAST) begin
                    travel_cnt_nx = '0;
                    floor_nx      = floor_up;
                    if (pend_car_q[floor_up] || pend_up_q[floor_up] ||
                        (pend_dn_q[floor_up] && !any_above(pend_any, floor_up))) begin
                        enter_door = 1'b1;
                        svc_floor  = floor_up;
                        svc_dir    = DIR_UP;
                    end
                end else begin
                    travel_cnt_nx = travel_cnt + CNT_W'(1);
                end
            end
            S_MOVE_DN: begin
                if (travel_cnt == TRAVEL_LAST) begin
                    travel_cnt_nx = '0;
                    floor_nx      = floor_dn;
                    if (pend_car_q[floor_dn] || pend_dn_q[floor_dn] ||
                        (pend_up_q[floor_dn] && !any_below(pend_any, floor_dn))) begin
                        enter_door = 1'b1;
                        svc_floor  = floor_dn;
                        svc_dir    = DIR_DN;
                    end
                end else begin
                    travel_cnt_nx = travel_cnt + CNT_W'(1);
                end
            end
            default: begin
                if (door_req) begin
                    door_cnt_nx      = '0;
                    clr_car[floor_q] = 1'b1;
                    if (dir == DIR_UP) clr_up[floor_q] = 1'b1;
                    else               clr_dn[floor_q] = 1'b1;
                end else if (door_cnt == DOOR_LAST) begin
                    door_cnt_nx = '0;
                    state_nx    = S_IDLE;
                end else begin
                    door_cnt_nx = door_cnt + CNT_W'(1);
                end
            end
        endcase

        if (enter_door) begin
            state_nx           = S_DOOR;
            door_cnt_nx        = '0;
            dir_nx             = svc_dir;
            clr_car[svc_floor] = 1'b1;
            if (svc_dir == DIR_UP) clr_up[svc_floor] = 1'b1;
            else                   clr_dn[svc_floor] = 1'b1;
            ahead = (svc_dir == DIR_UP) ? any_above(pend_any, svc_floor)
                                        : any_below(pend_any, svc_floor);
            if (!ahead) begin
                dir_nx             = ~svc_dir;
                clr_up[svc_floor]  = 1'b1;
                clr_dn[svc_floor]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            dir        <= DIR_UP;
            floor_q    <= '0;
            travel_cnt <= '0;
            door_cnt   <= '0;
            pend_up_q  <= '0;
            pend_dn_q  <= '0;
            pend_car_q <= '0;
        end else begin
            state      <= state_nx;
            dir        <= dir_nx;
            floor_q    <= floor_nx;
            travel_cnt <= travel_cnt_nx;
            door_cnt   <= door_cnt_nx;
            // Clear wins over a same-edge set on the same bit.
            pend_up_q  <= (pend_up_q  | req_up)      & ~clr_up;
            pend_dn_q  <= (pend_dn_q  | req_dn)      & ~clr_dn;
            pend_car_q <= (pend_car_q | bus.car_req) & ~clr_car;
        end
    end

    assign bus.cur_floor = floor_q;
    assign bus.moving_up = (state == S_MOVE_UP);
    assign bus.moving_dn = (state == S_MOVE_DN);
    assign bus.door_open = (state == S_DOOR);
    assign bus.busy      = (state != S_IDLE) || (|pend_any);
    assign bus.pend_up   = pend_up_q;
    assign bus.pend_dn   = pend_dn_q;
    assign bus.pend_car  = pend_car_q;
    assign bus.dbg_state = state;
    assign bus.dbg_dir   = dir;
endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Bench for elevator_ctrl_n with 5 floors, 4-cycle travel and 3-cycle door:
// a timeline of stimulus/expected-status vectors plus a mid-travel reset sequence.
module tb_elevator_ctrl_n;
    localparam int N  = 5;
    localparam int FW = 3;

    typedef struct packed {
        logic [FW-1:0] floor;
        logic          mu;
        logic          md;
        logic          door;
        logic          busy;
        logic [N-1:0]  pu;
        logic [N-1:0]  pd;
        logic [N-1:0]  pc;
    } stat_t;

    localparam int SW = $bits(stat_t);

    typedef struct {
        logic [N-1:0] up;
        logic [N-1:0] dn;
        logic [N-1:0] car;
        int           ticks;
        stat_t        exp;
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;
    logic [SW-1:0] exp_q[$];
    vec_t vecs[$];

    elevator_ctrl_n_if #(.N_FLOORS(N), .FLOOR_W(FW)) bus ();

    elevator_ctrl_n #(
        .N_FLOORS(N), .FLOOR_W(FW), .CNT_W(32),
        .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    function automatic stat_t st(input int fl, input logic mu, input logic md,
                                 input logic dr, input logic bz, input logic [N-1:0] pu,
                                 input logic [N-1:0] pd, input logic [N-1:0] pc);
        stat_t s;
        s.floor = FW'(fl);
        s.mu = mu; s.md = md; s.door = dr; s.busy = bz;
        s.pu = pu; s.pd = pd; s.pc = pc;
        return s;
    endfunction

    function automatic vec_t mkv(input logic [N-1:0] up, input logic [N-1:0] dn,
                                 input logic [N-1:0] car, input int ticks, input stat_t exp);
        vec_t v;
        v.up = up; v.dn = dn; v.car = car; v.ticks = ticks; v.exp = exp;
        return v;
    endfunction

    function automatic stat_t sample();
        stat_t s;
        s.floor = bus.cur_floor;
        s.mu = bus.moving_up; s.md = bus.moving_dn;
        s.door = bus.door_open; s.busy = bus.busy;
        s.pu = bus.pend_up; s.pd = bus.pend_dn; s.pc = bus.pend_car;
        return s;
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] up, input logic [N-1:0] dn, input logic [N-1:0] car);
        bus.hall_up_req = up;
        bus.hall_dn_req = dn;
        bus.car_req     = car;
    endtask

    // scoreboard
    task automatic score(input string name);
        stat_t got;
        stat_t want;
        got  = sample();
        want = stat_t'(exp_q.pop_front());
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got floor=%0d mu=%b md=%b door=%b busy=%b up=%b dn=%b car=%b, want floor=%0d mu=%b md=%b door=%b busy=%b up=%b dn=%b car=%b",
                     name, got.floor, got.mu, got.md, got.door, got.busy, got.pu, got.pd, got.pc,
                     want.floor, want.mu, want.md, want.door, want.busy, want.pu, want.pd, want.pc);
        end
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        drive(v.up, v.dn, v.car);
        exp_q.push_back(SW'(v.exp));
        for (int i = 0; i < v.ticks; i++) begin
            tick();
            if (i == 0) drive('0, '0, '0);
        end
        drive('0, '0, '0);
        score($sformatf("vec%0d", idx));
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;

        // reset state
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0, 0, st(0,0,0,0,0, 5'b0, 5'b0, 5'b0)));
        // single car call to floor 3 from floor 0
        vecs.push_back(mkv(5'b0, 5'b0, 5'b01000, 1, st(0,0,0,0,1, 5'b0, 5'b0, 5'b01000)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     1, st(0,1,0,0,1, 5'b0, 5'b0, 5'b01000)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     4, st(1,1,0,0,1, 5'b0, 5'b0, 5'b01000)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     3, st(1,1,0,0,1, 5'b0, 5'b0, 5'b01000)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     1, st(2,1,0,0,1, 5'b0, 5'b0, 5'b01000)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     4, st(3,0,0,1,1, 5'b0, 5'b0, 5'b0)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     2, st(3,0,0,1,1, 5'b0, 5'b0, 5'b0)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     1, st(3,0,0,0,0, 5'b0, 5'b0, 5'b0)));
        // ignored hall bits: up at top floor, down at bottom floor
        vecs.push_back(mkv(5'b10000, 5'b00001, 5'b0, 1, st(3,0,0,0,0, 5'b0, 5'b0, 5'b0)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,         2, st(3,0,0,0,0, 5'b0, 5'b0, 5'b0)));
        // down to floor 1
        vecs.push_back(mkv(5'b0, 5'b0, 5'b00010, 1, st(3,0,0,0,1, 5'b0, 5'b0, 5'b00010)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     1, st(3,0,1,0,1, 5'b0, 5'b0, 5'b00010)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     8, st(1,0,0,1,1, 5'b0, 5'b0, 5'b0)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     3, st(1,0,0,0,0, 5'b0, 5'b0, 5'b0)));
        // call at current floor, re-pressed in the 2nd door cycle
        vecs.push_back(mkv(5'b0, 5'b0, 5'b00010, 1, st(1,0,0,0,1, 5'b0, 5'b0, 5'b00010)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     1, st(1,0,0,1,1, 5'b0, 5'b0, 5'b0)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     1, st(1,0,0,1,1, 5'b0, 5'b0, 5'b0)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b00010, 1, st(1,0,0,1,1, 5'b0, 5'b0, 5'b0)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     2, st(1,0,0,1,1, 5'b0, 5'b0, 5'b0)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     1, st(1,0,0,0,0, 5'b0, 5'b0, 5'b0)));
        // hall up call at floor 0 served while moving down
        vecs.push_back(mkv(5'b00001, 5'b0, 5'b0, 1, st(1,0,0,0,1, 5'b00001, 5'b0, 5'b0)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     5, st(0,0,0,1,1, 5'b0, 5'b0, 5'b0)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     3, st(0,0,0,0,0, 5'b0, 5'b0, 5'b0)));
        // collective up sweep, pass down call at 2, reverse at 4
        vecs.push_back(mkv(5'b01000, 5'b00100, 5'b10000, 1, st(0,0,0,0,1, 5'b01000, 5'b00100, 5'b10000)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     9, st(2,1,0,0,1, 5'b01000, 5'b00100, 5'b10000)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     1, st(2,1,0,0,1, 5'b01000, 5'b00100, 5'b10000)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     3, st(3,0,0,1,1, 5'b0, 5'b00100, 5'b10000)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     3, st(3,0,0,0,1, 5'b0, 5'b00100, 5'b10000)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     1, st(3,1,0,0,1, 5'b0, 5'b00100, 5'b10000)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     4, st(4,0,0,1,1, 5'b0, 5'b00100, 5'b0)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     4, st(4,0,1,0,1, 5'b0, 5'b00100, 5'b0)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     8, st(2,0,0,1,1, 5'b0, 5'b0, 5'b0)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     3, st(2,0,0,0,0, 5'b0, 5'b0, 5'b0)));
        // at floor 2 heading down with calls both ways: down first, then up
        vecs.push_back(mkv(5'b0, 5'b00100, 5'b00001, 1, st(2,0,0,0,1, 5'b0, 5'b00100, 5'b00001)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     1, st(2,0,0,1,1, 5'b0, 5'b0, 5'b00001)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b10000, 1, st(2,0,0,1,1, 5'b0, 5'b0, 5'b10001)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     2, st(2,0,0,0,1, 5'b0, 5'b0, 5'b10001)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     1, st(2,0,1,0,1, 5'b0, 5'b0, 5'b10001)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     8, st(0,0,0,1,1, 5'b0, 5'b0, 5'b10000)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     4, st(0,1,0,0,1, 5'b0, 5'b0, 5'b10000)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,    16, st(4,0,0,1,1, 5'b0, 5'b0, 5'b0)));
        vecs.push_back(mkv(5'b0, 5'b0, 5'b0,     3, st(4,0,0,0,0, 5'b0, 5'b0, 5'b0)));
        // head for floor 0, caught at floor 2 mid-travel
        vecs.push_back(mkv(5'b0, 5'b0, 5'b00001, 10, st(2,0,1,0,1, 5'b0, 5'b0, 5'b00001)));

        rst = 1'b0;
        drive('0, '0, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            apply_vec(vecs[i], i);

        // asynchronous reset mid-travel, observed before any clock edge
        rst = 1'b0;
        exp_q.push_back(SW'(st(0,0,0,0,0, 5'b0, 5'b0, 5'b0)));
        #2;
        score("async_rst");
        tick();
        rst = 1'b1;
        exp_q.push_back(SW'(st(0,0,0,0,0, 5'b0, 5'b0, 5'b0)));
        tick();
        tick();
        score("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/elevator_ctrl_n.md
Name: elevator_ctrl_n

Overview:
- Parametrised elevator controller core: N floors, hall up/down call latching, car call latching, directional collective (SCAN) scheduling, per-floor travel timer and door timer.
- Drives floor-index, direction, door and call-lamp outputs.
- Replaces the fixed 5-floor controller; seven-segment and LED drivers in the top level consume its outputs.

Parameters:
- N_FLOORS, 5: number of floors, minimum 2; floor 0 is the bottom.
- FLOOR_W, 3: width of the floor index; must satisfy 2^FLOOR_W >= N_FLOORS.
- CNT_W, 32: width of the timer counters.
- TRAVEL_CYCLES, 100000000: clock cycles to move one floor; must be >= 1.
- DOOR_CYCLES, 100000000: clock cycles the door stays open; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- hall_up_req  in  N_FLOORS  up-call buttons, one bit per floor; bit N_FLOORS-1 is ignored.
- hall_dn_req  in  N_FLOORS  down-call buttons, one bit per floor; bit 0 is ignored.
- car_req  in  N_FLOORS  in-car destination buttons.
- cur_floor  out  FLOOR_W  current floor index.
- moving_up  out  1  car is travelling up.
- moving_dn  out  1  car is travelling down.
- door_open  out  1  door is open.
- busy  out  1  state is not IDLE, or any call is pending.
- pend_up  out  N_FLOORS  latched up calls (lamps).
- pend_dn  out  N_FLOORS  latched down calls (lamps).
- pend_car  out  N_FLOORS  latched car calls (lamps).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cur_floor=0, dir=UP, all pend_* bits=0, both counters=0, all outputs=0. Reset mid-travel or mid-door aborts immediately; there is no resume.
- Call latching: a request bit high at a clock edge sets its pend bit at that edge. Pend bits are sticky; pulse or level input both work. pend_up[N-1] and pend_dn[0] are constant 0.
- Clear wins over set on the same bit at the same edge.
- The FSM uses only registered pend_* bits. Latency from request edge k to leaving IDLE is edge k+1.
- Derived signals: above = any pend bit at a floor > cur_floor; below = any pend bit at a floor < cur_floor; here = pend_car[cur] | pend_up[cur] | pend_dn[cur].
- IDLE:
  - if here: go to DOOR.
  - else if above and below: move in dir (MOVE_UP if dir=UP, else MOVE_DN).
  - else if above: dir=UP, go to MOVE_UP.
  - else if below: dir=DN, go to MOVE_DN.
  - else stay in IDLE.
- MOVE_UP / MOVE_DN:
  - Travel counter increments each cycle.
  - When count = TRAVEL_CYCLES-1: cur_floor updates by ±1, counter returns to 0, and the stop test runs on the new floor f.
  - MOVE_UP stops if pend_car[f], or pend_up[f], or (pend_dn[f] and no calls above f).
  - MOVE_DN is the mirror: pend_car[f], or pend_dn[f], or (pend_up[f] and no calls below f).
  - On stop: go to DOOR. Otherwise remain in the move state.
  - moving_up / moving_dn are high for the whole state.
- DOOR entry clears pend_car[cur] and the hall call in the travel direction. If no calls remain ahead, dir flips and the opposite hall call at cur is cleared.
- DOOR:
  - door_open=1; door counter runs 0..DOOR_CYCLES-1, then state goes to IDLE with door_open=0 at the next edge.
  - A new request for cur_floor arriving in DOOR (car call, or hall call in the current dir) is cleared at once and restarts the door counter at 0.
- Boundaries:
  - MOVE_UP is never entered at floor N-1; MOVE_DN is never entered at floor 0.
  - cur_floor never leaves the range 0..N-1.
  - Requests arriving during travel are latched and take part in the next stop test.

Test Plan (N_FLOORS=5, TRAVEL_CYCLES=4, DOOR_CYCLES=3):
1. Hold rst=0 mid-simulation, with car at floor 2 and moving -> cur_floor=0, moving_*=0, door_open=0, pend_*=0 with no clock edge; busy=0 after release.
2. 1-cycle pulse on car_req[3] at floor 0 -> pend_car[3]=1 next edge; moving_up the following edge; cur_floor steps 1, 2, 3 every 4 cycles; at floor 3 door_open=1 for 3 cycles, pend_car[3]=0; back to IDLE, busy=0.
3. From floor 0 with car_req[4] set, press hall_dn_req[2] and hall_up_req[3] -> car passes floor 2 without stopping, stops at 3 (pend_up[3] clears), stops at 4, then reverses, stops at 2 and clears pend_dn[2].
4. Idle at floor 2 with dir=DN, car_req[4] and car_req[0] both pending -> car moves down first, serves 0, then goes up to 4.
5. Idle at floor 1, press car_req[1] -> door_open after 2 edges, no motion. Re-press car_req[1] on the 2nd door cycle -> door held a further 3 cycles.
6. Press hall_up_req[4] and hall_dn_req[0] -> pend bits stay 0, busy stays 0, no motion.
